// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop
// produce a - b - borrow_in LSB first, one bit per clock.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             bit_d, bit_br, last_bit;

    always_comb begin
        bit_d     = a_sr[0] ^ b_sr[0] ^ br;
        bit_br    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        // result fills from the MSB side; after the last bit it is fully aligned
        res_nxt   = {bit_d, res_sr};
        last_bit  = (cnt == CW'(WIDTH - 1));
        state_nxt = state;
        case (state)
            IDLE:  if (start)    state_nxt = SHIFT;
            SHIFT: if (last_bit) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_sr <= a;
                    b_sr <= b;
                    br   <= borrow_in;
                    cnt  <= '0;
                    busy <= 1'b1;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt[WIDTH-1:1];
                    br     <= bit_br;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff       <= res_nxt;
                        borrow_out <= bit_br;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        cnt        <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random 8-bit operations plus an
// exhaustive back-to-back sweep of a 4-bit instance, against arithmetic references.
module tb_serial_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, bin8, busy8, done8, bo8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bo4;
    logic [3:0] a4, b4, diff4;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_diff8 = '0;
    logic       exp_bo8 = 1'b0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {borrow, diff} of the unsigned subtraction, computed with plain arithmetic
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - 9'(c);
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - 5'(c);
    endfunction

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c, input string tag);
        int         nbusy;
        int         k;
        logic [8:0] r;
        r = ref8(x, y, c);
        a8 = x; b8 = y; bin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        nbusy = 0;
        k = 0;
        while (!done8 && k < 40) begin
            chk({tag, "_hold"}, 32'({bo8, diff8}), 32'({exp_bo8, exp_diff8}));
            if (busy8) nbusy++;
            k++;
            tick();
        end
        chk({tag, "_done"}, 32'(done8), 32'd1);
        chk({tag, "_busycyc"}, 32'(nbusy), 32'd8);
        chk({tag, "_busy_off"}, 32'(busy8), 32'd0);
        chk({tag, "_diff"}, 32'(diff8), 32'(r[7:0]));
        chk({tag, "_borrow"}, 32'(bo8), 32'(r[8]));
        exp_diff8 = r[7:0];
        exp_bo8   = r[8];
        tick();
        chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
        chk({tag, "_diff_held"}, 32'({bo8, diff8}), 32'({exp_bo8, exp_diff8}));
    endtask

    initial begin
        int         ndone;
        int         n;
        logic [7:0] cap_diff;
        logic       cap_bo;
        logic [4:0] r4;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        tick();
        tick();
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        chk("rst_bo8", 32'(bo8), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_out4", 32'({done4, bo4, diff4}), 32'd0);

        // reset wins over a simultaneous start
        start8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
        tick();
        chk("rst_prio_busy", 32'(busy8), 32'd0);
        start8 = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_prio_idle", 32'(busy8), 32'd0);

        run8(8'h05, 8'h03, 1'b0, "s05m03");
        run8(8'h03, 8'h05, 1'b0, "s03m05");
        run8(8'h00, 8'h00, 1'b1, "s00m00b");
        run8(8'hFF, 8'hFF, 1'b0, "sFFmFF");

        // start during busy is ignored, no restart and no queued second op
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ndone = 0; cap_diff = '0; cap_bo = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                ndone++;
                cap_diff = diff8;
                cap_bo = bo8;
            end
            tick();
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_diff", 32'(cap_diff), 32'h0F);
        chk("busy_start_bo", 32'(cap_bo), 32'd0);
        exp_diff8 = 8'h0F; exp_bo8 = 1'b0;

        // reset mid-operation aborts without exposing a partial result
        a8 = 8'h37; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_bo", 32'(bo8), 32'd0);
        exp_diff8 = '0; exp_bo8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || diff8 != 8'h00) ndone++;
            tick();
        end
        chk("abort_quiet", 32'(ndone), 32'd0);
        run8(8'h37, 8'h12, 1'b0, "post_rst");

        for (int i = 0; i < 20; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), "rand");

        // exhaustive 4-bit sweep with start held high: one op every 5 cycles
        a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0; start4 = 1'b1;
        tick();
        a4 = 4'd1; b4 = 4'd0; bin4 = 1'b0;
        for (int i = 0; i < 512; i++) begin
            n = 0;
            while (n < 20) begin
                tick();
                n++;
                if (n == 1 && i > 0) begin
                    if (i + 1 < 512) begin
                        a4 = 4'((i + 1) & 15); b4 = 4'(((i + 1) >> 4) & 15); bin4 = 1'(((i + 1) >> 8) & 1);
                    end else begin
                        start4 = 1'b0;
                    end
                end
                if (done4) break;
            end
            r4 = ref4(4'(i & 15), 4'((i >> 4) & 15), 1'((i >> 8) & 1));
            chk("ex4_done", 32'(done4), 32'd1);
            chk("ex4_spacing", 32'(n), (i == 0) ? 32'd4 : 32'd5);
            chk("ex4_diff", 32'(diff4), 32'(r4[3:0]));
            chk("ex4_borrow", 32'(bo4), 32'(r4[4]));
        end
        tick();
        chk("ex4_end_done", 32'(done4), 32'd0);
        tick();
        chk("ex4_end_idle", 32'(busy4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on clk rising edge.
REQ-005 Port: a  input  WIDTH  minuend.
REQ-006 Port: b  input  WIDTH  subtrahend.
REQ-007 Port: borrow_in  input  1  initial borrow into bit 0.
REQ-008 Port: busy  output  1  high while bits are being computed.
REQ-009 Port: done  output  1  single-cycle pulse marking diff/borrow_out valid.
REQ-010 Port: diff  output  WIDTH  result, equal to (a - b - borrow_in) mod 2^WIDTH.
REQ-011 Port: borrow_out  output  1  final borrow, high when a < b + borrow_in, unsigned.

Function
REQ-012 The block SHALL compute the result bit-serially, LSB first, one bit per clk cycle, using a single 1-bit full subtractor (d = x^y^br; br_next = (~x&y) | (~(x^y)&br)) and one borrow flip-flop.
REQ-013 The FSM SHALL have states IDLE and SHIFT only.
REQ-014 IDLE->SHIFT: on an edge with start=1 in IDLE, a, b and borrow_in SHALL be captured into internal shift/borrow registers, the bit counter cleared to 0, and busy set to 1.
REQ-015 a, b and borrow_in SHALL be ignored at every other edge; changes during SHIFT SHALL not affect the result.
REQ-016 SHIFT: each edge SHALL compute one bit, shift it into the result register from the MSB side, update the borrow flop, and increment the counter.
REQ-017 SHIFT->IDLE: on the edge that computes bit WIDTH-1, the block SHALL load diff and borrow_out, set done=1, clear busy, and return to IDLE.
REQ-018 Latency: start accepted at edge k -> done=1 and diff/borrow_out valid in the cycle after edge k+WIDTH, i.e. exactly WIDTH cycles of busy=1.
REQ-019 done SHALL be high for exactly one cycle per accepted start and SHALL deassert on the next edge.
REQ-020 diff and borrow_out SHALL update only at completion and SHALL hold their value until the next completion.
REQ-021 start=1 while busy=1 SHALL be ignored, with no queuing and no restart.
REQ-022 start=1 in the done cycle (state IDLE) SHALL be accepted, so back-to-back operations complete every WIDTH+1 cycles.
REQ-023 start held high continuously SHALL cause repeated operations, one accepted per IDLE cycle.
REQ-024 No combinational path SHALL exist from any input to any output; all outputs SHALL be registered.

Reset
REQ-025 With rst=1 at an edge, the block SHALL go to IDLE with busy=0, done=0, diff=0, borrow_out=0, the counter at 0 and the internal borrow at 0.
REQ-026 rst SHALL take priority over start at the same edge.
REQ-027 Reset during SHIFT SHALL abort the operation with no done pulse; the partial result SHALL never appear on diff.
REQ-028 After rst is released, the first start SHALL behave exactly as in REQ-014..REQ-018.

Verification
REQ-029 Scenario, WIDTH=8: a=0x05, b=0x03, borrow_in=0, start pulse -> busy for 8 cycles; then done=1, diff=0x02, borrow_out=0.
REQ-030 Scenario: a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1.
REQ-031 Scenario: a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1; then a=0xFF, b=0xFF, borrow_in=0 -> diff=0x00, borrow_out=0.
REQ-032 Scenario: start a=0x10, b=0x01, then at busy cycle 3 drive start=1 with a=0xAA, b=0x55 -> exactly one done, with diff=0x0F and borrow_out=0.
REQ-033 Scenario: assert rst at busy cycle 4 -> next cycle busy=0, done=0, diff=0x00; no done until a new start, which then yields the correct result.
REQ-034 Scenario: exhaustive at WIDTH=4 (all a, b, borrow_in, back-to-back starts) -> each result matches a - b - borrow_in mod 16 plus borrow, with a done spacing of 5 cycles.
